alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Sequencing is IDLE -> EXEC -> RESP, with one operation in flight at a time.
module alu_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [WIDTH-1:0]  req0_op2,
  input  logic [FUNC_W-1:0] req0_func,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [WIDTH-1:0]  req1_op2,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              req1_ready,
  output logic [WIDTH-1:0]  alu_op1,
  output logic [WIDTH-1:0]  alu_op2,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              rsp_ovf
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  op1_q, op2_q;
  logic [FUNC_W-1:0] func_q;
  logic              id_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic              rsp_id_q, rsp_zero_q, rsp_sign_q, rsp_ovf_q;
  logic              grant0, grant1, accept;

  // rst_n gates the readys so nothing can look accepted while reset is held.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = rst_n & (state_q == StIdle) & grant0;
    req1_ready = rst_n & (state_q == StIdle) & grant1;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StExec;
          last_grant_d = req1_ready;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= '0;
      op2_q  <= '0;
      func_q <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      op1_q  <= req1_ready ? req1_op1  : req0_op1;
      op2_q  <= req1_ready ? req1_op2  : req0_op2;
      func_q <= req1_ready ? req1_func : req0_func;
      id_q   <= req1_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_result_q <= alu_result;
      rsp_id_q     <= id_q;
      rsp_zero_q   <= alu_zero;
      rsp_sign_q   <= alu_sign;
      rsp_ovf_q    <= alu_ovf;
    end
  end

  // ALU inputs come only from the capture registers, so live requests never reach them.
  always_comb begin
    alu_op1    = op1_q;
    alu_op2    = op2_q;
    alu_func   = func_q;
    rsp_valid  = (state_q == StResp);
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_zero   = rsp_zero_q;
    rsp_sign   = rsp_sign_q;
    rsp_ovf    = rsp_ovf_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level model checked on every falling edge.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0] req0_func, req1_func;
  logic [7:0] alu_op1, alu_op2, alu_result;
  logic [2:0] alu_func;
  logic       alu_zero, alu_sign, alu_ovf;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_sign, rsp_ovf;
  logic [7:0] rsp_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .FUNC_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_func(req0_func), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_func(req1_func), .req1_ready(req1_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_ovf(rsp_ovf)
  );

  // ALU: {ovf, sign, zero, result}. 0 and, 1 or, 2 add, 3 sub, 4 xor, else pass op1.
  function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] f);
    logic [7:0] r;
    logic       o;
    o = 1'b0;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd3: begin r = a - b; o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd4: r = a ^ b;
      default: r = a;
    endcase
    return {o, r[7], (r == 8'd0), r};
  endfunction

  logic [10:0] alu_out;
  always_comb alu_out = alu_fn(alu_op1, alu_op2, alu_func);
  assign alu_result = alu_out[7:0];
  assign alu_zero   = alu_out[8];
  assign alu_sign   = alu_out[9];
  assign alu_ovf    = alu_out[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: busy between acceptance and response handshake; response
  // visible two cycles after the accepting cycle.
  bit          m_busy, m_last, m_id;
  int          m_resp_at, cyc = 0;
  logic [18:0] m_alu_in;
  logic [10:0] m_rsp;
  bit          e0, e1, ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp", {rsp_id, rsp_ovf, rsp_sign, rsp_zero, rsp_result}, 0);
      chk("rst_alu_in", {alu_op1, alu_op2, alu_func}, 0);
      m_busy = 0; m_last = 1; m_alu_in = '0;
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || m_last);
      e1 = !m_busy && req1_valid && !e0;
      ev = m_busy && (cyc >= m_resp_at);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", {rsp_ovf, rsp_sign, rsp_zero, rsp_result}, m_rsp);
      end
      chk("alu_in", {alu_op1, alu_op2, alu_func}, m_alu_in);
      if (ev && rsp_ready) m_busy = 0;
      if (e0 || e1) begin
        m_busy    = 1;
        m_resp_at = cyc + 2;
        m_id      = e1;
        m_last    = e1;
        m_alu_in  = e1 ? {req1_op1, req1_op2, req1_func} : {req0_op1, req0_op2, req0_func};
        m_rsp     = alu_fn(m_alu_in[18:11], m_alu_in[10:3], m_alu_in[2:0]);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] f, output logic [7:0] r, output logic [2:0] fl);
    int n;
    rsp_ready = 1;
    if (id) begin req1_valid = 1; req1_op1 = a; req1_op2 = b; req1_func = f; end
    else    begin req0_valid = 1; req0_op1 = a; req0_op2 = b; req0_func = f; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin tick(); n++; end
    chk("op_grant_bound", (n < 10), 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("op_rsp_bound", rsp_valid, 1);
    r  = rsp_result;
    fl = {rsp_ovf, rsp_sign, rsp_zero};
    tick();
  endtask

  bit         gq[$];
  int         cq[$];
  bit         idq[$];
  logic [7:0] r, hold;
  logic [2:0] fl;
  int         n;

  initial begin
    rst_n = 0; rsp_ready = 0;
    req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_func = 0;
    req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_func = 0;
    repeat (2) tick();
    rst_n = 1;

    // Single request: -8 + 1
    rsp_ready = 1;
    req0_valid = 1; req0_op1 = 8'hF8; req0_op2 = 8'h01; req0_func = 3'd2;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    #1 chk("t1_exec_no_rsp", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_result", rsp_result, 8'hF9);
    chk("t1_flags_osz", {rsp_ovf, rsp_sign, rsp_zero}, 3'b010);
    tick();

    // Tie straight after reset
    rst_n = 0;
    req0_valid = 1; req0_op1 = 8'h01; req0_op2 = 8'h02; req0_func = 3'd0;
    req1_valid = 1; req1_op1 = 8'h03; req1_op2 = 8'h04; req1_func = 3'd1;
    tick();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready || req1_ready) begin gq.push_back(req1_ready); cq.push_back(i); end
      if (rsp_valid && rsp_ready) idq.push_back(rsp_id);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("tie_grants", gq.size(), 4);
    chk("tie_rsps", idq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) begin
        chk("tie_grant_order", gq[k], k % 2);
        chk("tie_interval", cq[k], 3 * k);
      end
      if (k < idq.size()) chk("tie_rsp_id", idq[k], k % 2);
    end

    // Backpressure
    rsp_ready = 0;
    req0_valid = 1; req0_op1 = 8'h40; req0_op2 = 8'h13; req0_func = 3'd4;
    #1 chk("bp_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_op1 = 8'h09; req1_op2 = 8'h03; req1_func = 3'd3;
    n = 0;
    while (!rsp_valid && n < 5) begin tick(); n++; end
    chk("bp_reach_resp", rsp_valid, 1);
    hold = rsp_result;
    chk("bp_result", hold, 8'h53);
    repeat (5) begin
      #1;
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, hold);
      chk("bp_readys_low", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    rsp_ready = 1;
    #1 chk("bp_no_early_accept", req1_ready, 0);
    tick();
    #1 chk("bp_accept_after_hs", req1_ready, 1);
    tick();
    req1_valid = 0;
    n = 0;
    while (!rsp_valid && n < 5) begin tick(); n++; end
    chk("bp_second_result", rsp_result, 8'h06);
    tick();

    // Overflow and zero flag pass-through
    run_op(0, 8'h7F, 8'h01, 3'd2, r, fl);
    chk("ovf_result", r, 8'h80);
    chk("ovf_flags_osz", fl, 3'b110);
    run_op(1, 8'h05, 8'h05, 3'd3, r, fl);
    chk("zero_result", r, 8'h00);
    chk("zero_flags_osz", fl, 3'b001);

    // Reset during EXEC
    rsp_ready = 1;
    req0_valid = 1; req0_op1 = 8'h11; req0_op2 = 8'h22; req0_func = 3'd2;
    tick();
    req1_valid = 1;
    #1 rst_n = 0;
    #1;
    chk("mid_rst_alu_in", {alu_op1, alu_op2, alu_func}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_result}, 0);
    chk("mid_rst_readys", {req0_ready, req1_ready}, 0);
    tick();
    tick();
    req0_valid = 0; req1_valid = 0;
    rst_n = 1;
    repeat (4) begin
      #1 chk("post_rst_no_rsp", rsp_valid, 0);
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_tie0", req0_ready, 1);
    chk("post_rst_tie1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    tick();

    // Input churn during EXEC/RESP
    req0_valid = 1; req0_op1 = 8'h10; req0_op2 = 8'h22; req0_func = 3'd2;
    tick();
    req0_valid = 0; req0_op1 = 8'hFF;
    #1 chk("churn_exec_op1", alu_op1, 8'h10);
    tick();
    req0_op1 = 8'h5A;
    #1;
    chk("churn_rsp_valid", rsp_valid, 1);
    chk("churn_result", rsp_result, 8'h32);
    chk("churn_resp_op1", alu_op1, 8'h10);
    tick();

    // Random traffic, model-checked every cycle
    repeat (600) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op1 = 8'($urandom); req0_op2 = 8'($urandom); req0_func = 3'($urandom);
      req1_op1 = 8'($urandom); req1_op2 = 8'($urandom); req1_func = 3'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
